// File: rtl/alu_regfile_defs.sv
// rtl/alu_regfile_defs.sv - shared widths and types for the register file and ALU sequencer
//   REGFILE_WIDTH / REGFILE_ADDR_WIDTH : data and address widths of the register file
//   SHAMT_WIDTH                        : shift-amount width taken from operand B
//   alu_op_t, alu_flags_t, seq_state_t : ALU opcode, result flags, sequencer FSM state
package alu_regfile_defs;

  localparam int REGFILE_WIDTH      = 16;
  localparam int REGFILE_ADDR_WIDTH = 4;
  localparam int SHAMT_WIDTH        = $clog2(REGFILE_WIDTH);

  typedef enum logic [2:0] {
    OP_ADD   = 3'd0,
    OP_SUB   = 3'd1,
    OP_AND   = 3'd2,
    OP_OR    = 3'd3,
    OP_XOR   = 3'd4,
    OP_SLL   = 3'd5,
    OP_SRL   = 3'd6,
    OP_PASSB = 3'd7
  } alu_op_t;

  typedef struct packed {
    logic z;
    logic c;
    logic v;
  } alu_flags_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WRITE = 2'd3
  } seq_state_t;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational ALU producing a result and Z/C/V flags
//   a, b   : operands
//   op     : operation select
//   result : a op b, modulo 2^DATA_WIDTH
//   flags  : Z for every op, C/V for ADD and SUB only
module alu_core
  import alu_regfile_defs::*;
#(
  parameter int DATA_WIDTH = REGFILE_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  alu_op_t               op,
  output logic [DATA_WIDTH-1:0] result,
  output alu_flags_t            flags
);

  localparam int SW  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int MSB = DATA_WIDTH - 1;

  logic [DATA_WIDTH:0] sum_ext;
  logic [DATA_WIDTH:0] diff_ext;
  logic [SW-1:0]       shamt;

  always_comb begin
    // One extra bit holds carry-out on ADD and borrow on SUB.
    sum_ext  = {1'b0, a} + {1'b0, b};
    diff_ext = {1'b0, a} - {1'b0, b};
    shamt    = b[SW-1:0];
    result   = '0;
    flags    = '0;
    case (op)
      OP_ADD: begin
        result  = sum_ext[MSB:0];
        flags.c = sum_ext[DATA_WIDTH];
        // Overflow: like-signed operands giving an opposite-signed sum.
        flags.v = (a[MSB] == b[MSB]) && (result[MSB] != a[MSB]);
      end
      OP_SUB: begin
        result  = diff_ext[MSB:0];
        flags.c = diff_ext[DATA_WIDTH];
        // Overflow: differing signs and the difference takes the sign of B.
        flags.v = (a[MSB] != b[MSB]) && (result[MSB] != a[MSB]);
      end
      OP_AND:   result = a & b;
      OP_OR:    result = a | b;
      OP_XOR:   result = a ^ b;
      OP_SLL:   result = a << shamt;
      OP_SRL:   result = a >> shamt;
      OP_PASSB: result = b;
      default:  result = '0;
    endcase
    flags.z = (result == '0);
  end

endmodule

// File: rtl/register_file.sv
// rtl/register_file.sv - register file with two combinational read ports and one write port
//   Clock                    : rising-edge clock
//   Read_Addr_1/2, Data_Out_1/2 : asynchronous read ports
//   Write_Addr, Data_In, Write_enable : synchronous write port
//   Contents have no reset.
module register_file
  import alu_regfile_defs::*;
#(
  parameter int DATA_WIDTH = REGFILE_WIDTH,
  parameter int ADDR_WIDTH = REGFILE_ADDR_WIDTH
) (
  input  logic                  Clock,
  input  logic [ADDR_WIDTH-1:0] Read_Addr_1,
  input  logic [ADDR_WIDTH-1:0] Read_Addr_2,
  output logic [DATA_WIDTH-1:0] Data_Out_1,
  output logic [DATA_WIDTH-1:0] Data_Out_2,
  input  logic [ADDR_WIDTH-1:0] Write_Addr,
  input  logic [DATA_WIDTH-1:0] Data_In,
  input  logic                  Write_enable
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

  always_ff @(posedge Clock) begin
    if (Write_enable) begin
      mem_q[Write_Addr] <= Data_In;
    end
  end

  assign Data_Out_1 = mem_q[Read_Addr_1];
  assign Data_Out_2 = mem_q[Read_Addr_2];

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - four-state command sequencer: read two registers, run the ALU, write back
//   Clock, Reset                      : rising-edge clock, synchronous active-high reset
//   Cmd_Valid/Cmd_Ready, Cmd_*        : command handshake and fields
//   Read_Addr_1/2, Data_Out_1/2       : register file read ports
//   Write_Addr, Data_In, Write_enable : register file write port
//   Result, Flags, Done               : last result/flags and writeback pulse
module alu_sequencer
  import alu_regfile_defs::*;
#(
  parameter int DATA_WIDTH = REGFILE_WIDTH,
  parameter int ADDR_WIDTH = REGFILE_ADDR_WIDTH
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Cmd_Valid,
  output logic                  Cmd_Ready,
  input  alu_op_t               Cmd_Op,
  input  logic [ADDR_WIDTH-1:0] Cmd_Rs1,
  input  logic [ADDR_WIDTH-1:0] Cmd_Rs2,
  input  logic [ADDR_WIDTH-1:0] Cmd_Rd,
  input  logic                  Cmd_Use_Imm,
  input  logic [DATA_WIDTH-1:0] Cmd_Imm,
  output logic [ADDR_WIDTH-1:0] Read_Addr_1,
  output logic [ADDR_WIDTH-1:0] Read_Addr_2,
  input  logic [DATA_WIDTH-1:0] Data_Out_1,
  input  logic [DATA_WIDTH-1:0] Data_Out_2,
  output logic [ADDR_WIDTH-1:0] Write_Addr,
  output logic [DATA_WIDTH-1:0] Data_In,
  output logic                  Write_enable,
  output logic [DATA_WIDTH-1:0] Result,
  output alu_flags_t            Flags,
  output logic                  Done
);

  seq_state_t            state_q,   state_d;
  alu_op_t               op_q,      op_d;
  logic [ADDR_WIDTH-1:0] rs1_q,     rs1_d;
  logic [ADDR_WIDTH-1:0] rs2_q,     rs2_d;
  logic [ADDR_WIDTH-1:0] rd_q,      rd_d;
  logic                  use_imm_q, use_imm_d;
  logic [DATA_WIDTH-1:0] imm_q,     imm_d;
  logic [DATA_WIDTH-1:0] opa_q,     opa_d;
  logic [DATA_WIDTH-1:0] opb_q,     opb_d;
  logic [DATA_WIDTH-1:0] result_q,  result_d;
  alu_flags_t            flags_q,   flags_d;

  logic [DATA_WIDTH-1:0] alu_result;
  alu_flags_t            alu_flags;

  alu_core #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_alu_core (
    .a      (opa_q),
    .b      (opb_q),
    .op     (op_q),
    .result (alu_result),
    .flags  (alu_flags)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rd_d      = rd_q;
    use_imm_d = use_imm_q;
    imm_d     = imm_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    result_d  = result_q;
    flags_d   = flags_q;
    case (state_q)
      ST_IDLE: begin
        if (Cmd_Valid) begin
          op_d      = Cmd_Op;
          rs1_d     = Cmd_Rs1;
          rs2_d     = Cmd_Rs2;
          rd_d      = Cmd_Rd;
          use_imm_d = Cmd_Use_Imm;
          imm_d     = Cmd_Imm;
          state_d   = ST_READ;
        end
      end
      ST_READ: begin
        // Operands are frozen here, so a write to Rd cannot disturb them.
        opa_d   = Data_Out_1;
        opb_d   = use_imm_q ? imm_q : Data_Out_2;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        result_d = alu_result;
        flags_d  = alu_flags;
        state_d  = ST_WRITE;
      end
      ST_WRITE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_ADD;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      use_imm_q <= 1'b0;
      imm_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      result_q  <= '0;
      flags_q   <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rd_q      <= rd_d;
      use_imm_q <= use_imm_d;
      imm_q     <= imm_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      result_q  <= result_d;
      flags_q   <= flags_d;
    end
  end

  assign Cmd_Ready   = (state_q == ST_IDLE);
  assign Read_Addr_1 = rs1_q;
  assign Read_Addr_2 = rs2_q;
  assign Write_Addr  = rd_q;
  assign Data_In     = result_q;
  assign Result      = result_q;
  assign Flags       = flags_q;
  // Reset in the WRITE cycle must suppress the commit and the completion pulse.
  assign Write_enable = (state_q == ST_WRITE) && !Reset;
  assign Done         = (state_q == ST_WRITE) && !Reset;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - scoreboard bench for alu_sequencer driving register_file
module tb_alu_sequencer;
  import alu_regfile_defs::*;

  localparam int DW = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  alu_op_t       cmd_op = OP_ADD;
  logic [AW-1:0] cmd_rs1 = '0, cmd_rs2 = '0, cmd_rd = '0;
  logic          cmd_use_imm = 1'b0;
  logic [DW-1:0] cmd_imm = '0;
  logic [AW-1:0] ra1, ra2, wa;
  logic [DW-1:0] do1, do2, din, result;
  logic          we, done;
  alu_flags_t    flags;

  always #5 clk = ~clk;

  alu_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .Clock(clk), .Reset(rst),
    .Cmd_Valid(cmd_valid), .Cmd_Ready(cmd_ready), .Cmd_Op(cmd_op),
    .Cmd_Rs1(cmd_rs1), .Cmd_Rs2(cmd_rs2), .Cmd_Rd(cmd_rd),
    .Cmd_Use_Imm(cmd_use_imm), .Cmd_Imm(cmd_imm),
    .Read_Addr_1(ra1), .Read_Addr_2(ra2), .Data_Out_1(do1), .Data_Out_2(do2),
    .Write_Addr(wa), .Data_In(din), .Write_enable(we),
    .Result(result), .Flags(flags), .Done(done)
  );

  register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) u_rf (
    .Clock(clk), .Read_Addr_1(ra1), .Read_Addr_2(ra2),
    .Data_Out_1(do1), .Data_Out_2(do2),
    .Write_Addr(wa), .Data_In(din), .Write_enable(we)
  );

  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] res;
    logic [2:0]    flg;
  } exp_t;

  exp_t          sb_q[$];
  exp_t          mon_e;
  logic [DW-1:0] model_rf[16];
  int            checks = 0;
  int            failures = 0;
  int            pushed = 0;
  int            done_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // Reference: plain integer arithmetic on the spec's rules.
  function automatic void model_exec(input int op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                                     output logic [DW-1:0] r, output logic [2:0] f);
    int ua = int'(a);
    int ub = int'(b);
    int sa = int'($signed(a));
    int sb = int'($signed(b));
    int full = 0;
    int sfull = 0;
    bit c = 0;
    bit v = 0;
    case (op)
      0: begin full = ua + ub; sfull = sa + sb; c = (full > 65535); v = (sfull > 32767) || (sfull < -32768); end
      1: begin full = ua - ub; sfull = sa - sb; c = (ua < ub);     v = (sfull > 32767) || (sfull < -32768); end
      2: full = ua & ub;
      3: full = ua | ub;
      4: full = ua ^ ub;
      5: full = ua << (ub % 16);
      6: full = ua >> (ub % 16);
      default: full = ub;
    endcase
    r = full[DW-1:0];
    f = {(r == 0), c, v};
  endfunction

  task automatic wait_idle(input string name);
    int n = 0;
    while (!cmd_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!cmd_ready) fail_now(name);
  endtask

  // Returns at cycle N+1 (#1 after the accepting edge).
  task automatic issue(input int op, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                       input logic [AW-1:0] rd, input bit use_imm, input logic [DW-1:0] imm,
                       input bit track);
    logic [DW-1:0] a, b, r;
    logic [2:0]    f;
    exp_t          e;
    wait_idle("ready_before_issue");
    cmd_valid   = 1'b1;
    cmd_op      = alu_op_t'(op);
    cmd_rs1     = rs1;
    cmd_rs2     = rs2;
    cmd_rd      = rd;
    cmd_use_imm = use_imm;
    cmd_imm     = imm;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (track) begin
      a = model_rf[rs1];
      b = use_imm ? imm : model_rf[rs2];
      model_exec(op, a, b, r, f);
      e.rd = rd; e.res = r; e.flg = f;
      sb_q.push_back(e);
      pushed++;
      model_rf[rd] = r;
    end
  endtask

  // Monitor: every writeback is matched against the oldest expected entry.
  always @(negedge clk) begin
    if (done === 1'b1 && rst === 1'b0) begin
      done_count++;
      if (sb_q.size() == 0) begin
        fail_now("unexpected_done");
      end else begin
        mon_e = sb_q.pop_front();
        check("wb_enable", {31'd0, we}, 32'd1);
        check("wb_addr", {28'd0, wa}, {28'd0, mon_e.rd});
        check("wb_data", {16'd0, din}, {16'd0, mon_e.res});
        check("wb_result", {16'd0, result}, {16'd0, mon_e.res});
        check("wb_flags", {29'd0, flags}, {29'd0, mon_e.flg});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) model_rf[i] = '0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_outputs", {ra1, ra2, wa, din, result, flags, we, done},
          {4'd0, 4'd0, 4'd0, 16'd0, 16'd0, 3'd0, 1'b0, 1'b0});

    for (int r = 0; r < 16; r++) issue(7, 4'(r), 4'(r), 4'(r), 1'b1, 16'($urandom), 1'b1);

    // Immediate load with cycle-accurate latency observation.
    issue(7, 4'd0, 4'd0, 4'd3, 1'b1, 16'h1234, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("lat_done_n%0d", k), {31'd0, done}, {31'd0, (k == 3)});
      check($sformatf("lat_ready_n%0d", k), {31'd0, cmd_ready}, {31'd0, (k == 4)});
      if (k < 4) begin @(posedge clk); #1; end
    end
    issue(7, 4'd3, 4'd3, 4'd9, 1'b0, 16'h0, 1'b1);
    check("read_addr1", {28'd0, ra1}, 32'd3);
    check("read_data1", {16'd0, do1}, 32'h1234);
    wait_idle("imm_idle");
    check("imm_result", {16'd0, result}, 32'h1234);
    check("imm_flags", {29'd0, flags}, 32'd0);

    // ADD carry.
    issue(7, 4'd0, 4'd0, 4'd1, 1'b1, 16'hFFFF, 1'b1);
    issue(7, 4'd0, 4'd0, 4'd2, 1'b1, 16'h0001, 1'b1);
    issue(0, 4'd1, 4'd2, 4'd4, 1'b0, 16'h0, 1'b1);
    wait_idle("add_idle");
    check("add_result", {16'd0, result}, 32'h0000);
    check("add_flags", {29'd0, flags}, 32'b110);

    // SUB overflow and borrow.
    issue(7, 4'd0, 4'd0, 4'd1, 1'b1, 16'h8000, 1'b1);
    issue(1, 4'd1, 4'd2, 4'd5, 1'b0, 16'h0, 1'b1);
    wait_idle("sub_idle");
    check("sub_result", {16'd0, result}, 32'h7FFF);
    check("sub_flags", {29'd0, flags}, 32'b001);
    issue(1, 4'd2, 4'd1, 4'd11, 1'b0, 16'h0, 1'b1);
    wait_idle("subr_idle");
    check("subr_result", {16'd0, result}, 32'h8001);
    check("subr_flags", {29'd0, flags}, 32'b011);

    // Aliasing, then a back-to-back dependent shift.
    issue(7, 4'd0, 4'd0, 4'd6, 1'b1, 16'd5, 1'b1);
    issue(0, 4'd6, 4'd6, 4'd6, 1'b0, 16'h0, 1'b1);
    wait_idle("alias_idle");
    check("alias_result", {16'd0, result}, 32'd10);
    issue(5, 4'd6, 4'd0, 4'd7, 1'b1, 16'd4, 1'b1);
    wait_idle("sll_idle");
    check("sll_result", {16'd0, result}, 32'h00A0);

    // Valid held high with changing fields while busy: only the first is taken.
    issue(0, 4'd6, 4'd7, 4'd12, 1'b0, 16'h0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      cmd_valid = 1'b1;
      cmd_op    = alu_op_t'($urandom_range(0, 7));
      cmd_rs1   = 4'($urandom); cmd_rs2 = 4'($urandom); cmd_rd = 4'($urandom);
      cmd_use_imm = 1'($urandom); cmd_imm = 16'($urandom);
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    check("hs_ready_back", {31'd0, cmd_ready}, 32'd1);

    // Reset in the WRITE cycle drops the command.
    issue(7, 4'd0, 4'd0, 4'd8, 1'b1, 16'h00AA, 1'b1);
    issue(0, 4'd1, 4'd2, 4'd8, 1'b0, 16'h0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rstw_we", {31'd0, we}, 32'd0);
    check("rstw_done", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("rstw_ready", {31'd0, cmd_ready}, 32'd1);
    check("rstw_outputs", {ra1, ra2, wa, din, result, flags, we, done},
          {4'd0, 4'd0, 4'd0, 16'd0, 16'd0, 3'd0, 1'b0, 1'b0});
    issue(7, 4'd8, 4'd8, 4'd10, 1'b0, 16'h0, 1'b1);
    wait_idle("r8_idle");
    check("r8_kept", {16'd0, result}, 32'h00AA);

    // Randomized commands against the model.
    for (int i = 0; i < 150; i++) begin
      issue($urandom_range(0, 7), 4'($urandom), 4'($urandom), 4'($urandom),
            1'($urandom), ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom), 1'b1);
    end

    // Read every register back through the datapath.
    for (int r = 0; r < 16; r++) issue(7, 4'(r), 4'(r), 4'(r), 1'b0, 16'h0, 1'b1);

    begin
      int n = 0;
      while (sb_q.size() != 0 && n < 50) begin
        @(posedge clk); #1; n++;
      end
    end
    check("sb_drained", sb_q.size(), 32'd0);
    check("done_count", done_count, pushed);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
